// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the main pipeline and a FIFO-buffered special-result path
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic                            pipe_wr_en,
  input  logic [REG_AW-1:0]               pipe_wr_reg,
  input  logic [DATA_W-1:0]               pipe_wr_data,
  input  logic                            spec_wr_en,
  input  logic [REG_AW-1:0]               spec_wr_reg,
  input  logic [DATA_W-1:0]               spec_wr_data,
  output logic                            spec_ready,
  output logic                            pipe_stall,
  output logic                            WB_RegWrite,
  output logic [REG_AW-1:0]               WB_WriteRegister,
  output logic [DATA_W-1:0]               WB_WriteData,
  input  logic [REG_AW-1:0]               ID_rs,
  input  logic [REG_AW-1:0]               ID_rt,
  output logic                            rs_pending,
  output logic                            rt_pending,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [REG_AW-1:0] mem_reg  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]     off      [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [WW-1:0]     wait_cnt;
  logic              pipe_valid, spec_valid, non_empty, forced, grant_pipe, deq, byp, enq;
  assign fifo_count = count;
  assign pipe_valid = pipe_wr_en && (pipe_wr_reg != '0);
  assign spec_valid = spec_wr_en && (spec_wr_reg != '0);
  assign non_empty  = count != '0;
  assign spec_ready = Rst_n && (count < CW'(FIFO_DEPTH));
  assign forced     = non_empty && (wait_cnt == WW'(MAX_WAIT));
  assign pipe_stall = forced && pipe_valid;
  assign grant_pipe = pipe_valid && !forced;
  assign deq        = forced || (!pipe_valid && non_empty);
  assign byp        = !pipe_valid && !non_empty && spec_valid && spec_ready;
  assign enq        = spec_valid && spec_ready && !byp;
  // Pending query: entries between head and count are live, including a head leaving this cycle
  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      off[j] = PW'(j) - rd_ptr;
      rs_pending = rs_pending | ((CW'(off[j]) < count) && (mem_reg[j] == ID_rs));
      rt_pending = rt_pending | ((CW'(off[j]) < count) && (mem_reg[j] == ID_rt));
    end
    rs_pending = rs_pending && (ID_rs != '0);
    rt_pending = rt_pending && (ID_rt != '0);
  end
  // FIFO storage needs no reset; validity lives in the pointers and count
  always_ff @(posedge Clk) begin
    if (enq) begin
      mem_reg[wr_ptr]  <= spec_wr_reg;
      mem_data[wr_ptr] <= spec_wr_data;
    end
  end
  // Pointers, age counter, registered write-port outputs and sticky overflow flag
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      wait_cnt         <= '0;
      WB_RegWrite      <= 1'b0;
      WB_WriteRegister <= '0;
      WB_WriteData     <= '0;
      overflow_err     <= 1'b0;
    end else begin
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      count            <= count + CW'(enq) - CW'(deq);
      wait_cnt         <= (deq || !non_empty) ? '0 : forced ? wait_cnt : wait_cnt + 1'b1;
      WB_RegWrite      <= deq || grant_pipe || byp;
      WB_WriteRegister <= deq ? mem_reg[rd_ptr] : grant_pipe ? pipe_wr_reg : byp ? spec_wr_reg : '0;
      WB_WriteData     <= deq ? mem_data[rd_ptr] : grant_pipe ? pipe_wr_data : byp ? spec_wr_data : '0;
      if (spec_wr_en && !spec_ready) overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the write-port arbiter against a queue-based model
module tb_regfile_wb_arbiter;
  localparam int DW = 32, AW = 5, D = 4, MW = 3;
  logic          Clk = 1'b0, Rst_n = 1'b0;
  logic          pipe_wr_en = 1'b0, spec_wr_en = 1'b0;
  logic [AW-1:0] pipe_wr_reg = '0, spec_wr_reg = '0, ID_rs = '0, ID_rt = '0;
  logic [DW-1:0] pipe_wr_data = '0, spec_wr_data = '0;
  logic          spec_ready, pipe_stall, WB_RegWrite, rs_pending, rt_pending, overflow_err;
  logic [AW-1:0] WB_WriteRegister;
  logic [DW-1:0] WB_WriteData;
  logic [2:0]    fifo_count;

  regfile_wb_arbiter #(.DATA_W(DW), .REG_AW(AW), .FIFO_DEPTH(D), .MAX_WAIT(MW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
    .spec_wr_en(spec_wr_en), .spec_wr_reg(spec_wr_reg), .spec_wr_data(spec_wr_data),
    .spec_ready(spec_ready), .pipe_stall(pipe_stall),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
    .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            wt = 0;
  bit            m_ovf = 0, m_we = 0, last_stall = 0, last_pend = 0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  int            n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pend(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
    foreach (q[i]) if (q[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    bit rdy, pv, sv, forced, byp, was_empty;
    ent_t e;
    #1;
    rdy    = Rst_n && (q.size() < D);
    pv     = pipe_wr_en && (pipe_wr_reg != '0);
    sv     = spec_wr_en && (spec_wr_reg != '0);
    forced = (q.size() > 0) && (wt == MW);
    last_stall = forced && pv;
    last_pend  = pend(ID_rs);
    chk("spec_ready", spec_ready, rdy);
    chk("pipe_stall", pipe_stall, last_stall);
    chk("rs_pending", rs_pending, last_pend);
    chk("rt_pending", rt_pending, pend(ID_rt));
    @(posedge Clk);
    if (!Rst_n) begin
      q.delete();
      wt = 0; m_ovf = 0; m_we = 0;
    end else begin
      was_empty = q.size() == 0;
      byp = 0;
      m_we = 1;
      if (forced || (!pv && !was_empty)) begin
        e = q.pop_front(); m_wr = e.r; m_wd = e.d;
        wt = 0;
      end else begin
        wt = was_empty ? 0 : (wt < MW ? wt + 1 : MW);
        if (pv) begin m_wr = pipe_wr_reg; m_wd = pipe_wr_data; end
        else if (sv && rdy) begin m_wr = spec_wr_reg; m_wd = spec_wr_data; byp = 1; end
        else m_we = 0;
      end
      if (sv && rdy && !byp) begin e.r = spec_wr_reg; e.d = spec_wr_data; q.push_back(e); end
      if (spec_wr_en && !rdy) m_ovf = 1;
    end
    #1;
    chk("WB_RegWrite", WB_RegWrite, m_we);
    if (m_we) begin
      chk("WB_WriteRegister", WB_WriteRegister, m_wr);
      chk("WB_WriteData", WB_WriteData, m_wd);
    end
    chk("fifo_count", fifo_count, q.size());
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic idle();
    pipe_wr_en = 0; pipe_wr_reg = '0; pipe_wr_data = '0;
    spec_wr_en = 0; spec_wr_reg = '0; spec_wr_data = '0;
    ID_rs = '0; ID_rt = '0;
  endtask

  task automatic do_reset();
    idle();
    Rst_n = 0;
    step();
    step();
    Rst_n = 1;
  endtask

  initial begin
    @(posedge Clk);
    #1;
    // T1: reset with random inputs
    Rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      pipe_wr_en = 1'($urandom); pipe_wr_reg = AW'($urandom); pipe_wr_data = $urandom;
      spec_wr_en = 1'($urandom); spec_wr_reg = AW'($urandom); spec_wr_data = $urandom;
      step();
    end
    Rst_n = 1;
    idle();
    step();
    chk("t1_ready_after_release", spec_ready, 1'b1);
    // T2: bypass
    spec_wr_en = 1; spec_wr_reg = 5'd9; spec_wr_data = 32'hA5A5_0001;
    step();
    chk("t2_we", WB_RegWrite, 1'b1);
    chk("t2_reg", WB_WriteRegister, 5'd9);
    chk("t2_data", WB_WriteData, 32'hA5A5_0001);
    chk("t2_count", fifo_count, 3'd0);
    idle();
    step();
    // T3: starvation bound
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (!last_stall) begin
        pipe_wr_en = 1; pipe_wr_reg = AW'(i + 1); pipe_wr_data = 32'h100 + i;
      end
      spec_wr_en = (i == 0); spec_wr_reg = 5'd20; spec_wr_data = 32'h2020;
      step();
      if (i == 4) begin
        chk("t3_stall", last_stall, 1'b1);
        chk("t3_forced_reg", WB_WriteRegister, 5'd20);
      end
      if (i == 5) chk("t3_held_reg", WB_WriteRegister, 5'd5);
    end
    // T4: fill and overflow, then drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pipe_wr_en = 1; pipe_wr_reg = 5'd1; pipe_wr_data = i;
      spec_wr_en = 1; spec_wr_reg = AW'(21 + i); spec_wr_data = 32'hC000 + i;
      step();
      if (last_stall) break;
    end
    chk("t4_overflow", overflow_err, 1'b1);
    idle();
    for (int i = 0; i < 6; i++) step();
    // T5: pending query and reg-0 writes
    do_reset();
    pipe_wr_en = 1; pipe_wr_reg = 5'd3; pipe_wr_data = 32'h33;
    spec_wr_en = 1; spec_wr_reg = 5'd12; spec_wr_data = 32'h1212;
    step();
    spec_wr_en = 0; ID_rs = 5'd12; ID_rt = 5'd0;
    step();
    chk("t5_rs_pending", last_pend, 1'b1);
    pipe_wr_en = 0;
    step();
    step();
    chk("t5_rs_cleared", rs_pending, 1'b0);
    pipe_wr_en = 1; pipe_wr_reg = '0; spec_wr_en = 1; spec_wr_reg = '0;
    step();
    chk("t5_reg0_nowrite", WB_RegWrite, 1'b0);
    // T6: reset mid-drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pipe_wr_en = 1; pipe_wr_reg = 5'd2; pipe_wr_data = i;
      spec_wr_en = 1; spec_wr_reg = AW'(26 + i); spec_wr_data = i;
      step();
    end
    chk("t6_count3", fifo_count, 3'd3);
    idle();
    Rst_n = 0;
    step();
    Rst_n = 1;
    for (int i = 0; i < 4; i++) step();
    // Randomized phase
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      Rst_n = $urandom_range(0, 299) != 0;
      if (!last_stall) begin
        pipe_wr_en = $urandom_range(0, 99) < 60;
        pipe_wr_reg = AW'($urandom);
        pipe_wr_data = $urandom;
      end
      spec_wr_en = $urandom_range(0, 99) < 50;
      spec_wr_reg = AW'($urandom);
      spec_wr_data = $urandom;
      ID_rs = AW'($urandom);
      ID_rt = (q.size() > 0 && $urandom_range(0, 1)) ? q[0].r : AW'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
